udp_port_router: RTL
====================

Name: udp_port_router

Overview:
- Parametrised successor to the single-port UDP echo path. Sits between eth_rx_parse and the application and TX layers.
- Accepts UDP payloads addressed to NUM_PORTS consecutive listen ports and stages them in a shared byte buffer.
- Commits a datagram only when its frame completes good; otherwise it rolls the datagram back.
- Presents committed datagrams as a valid/ready byte stream with a per-datagram descriptor.

Parameters:
- NUM_PORTS, 4: number of listen ports; channel k listens on PORT_BASE+k.
- PORT_BASE, 16'd5005: first listen port.
- BUF_AW, 11: payload buffer address width; depth 2^BUF_AW bytes.
- DESC_AW, 3: descriptor FIFO address width; depth 2^DESC_AW entries.
- FPGA_IP, 32'hC0A80164: local IP, used only by the optional feature.

Ports:
- clk50  in  1  50 MHz clock.
- rst_n  in  1  synchronous active-low reset.
- is_udp  in  1  parser: current frame is IPv4/UDP.
- dst_ip  in  32  parser: IPv4 destination.
- src_ip  in  32  parser: IPv4 source.
- src_mac  in  48  parser: Ethernet source.
- udp_src_port  in  16  parser.
- udp_dst_port  in  16  parser.
- udp_payload  in  8  payload byte.
- udp_payload_valid  in  1  payload byte strobe.
- udp_payload_last  in  1  last payload byte.
- frame_done  in  1  one-cycle end-of-frame pulse.
- frame_ok  in  1  FCS/length good; sampled with frame_done.
- out_valid  out  1  stream byte valid.
- out_ready  in  1  consumer ready.
- out_data  out  8  stream byte.
- out_last  out  1  final byte of datagram.
- out_chan  out  $clog2(NUM_PORTS) (min 1)  channel index.
- out_len  out  11  payload length in bytes.
- out_src_ip  out  32  descriptor field.
- out_src_mac  out  48  descriptor field.
- out_src_port  out  16  descriptor field.
- drop_cnt  out  16  dropped datagrams, wrapping.
- pkt_cnt  out  16  committed datagrams, wrapping.

Behaviour:
- Reset: all outputs 0. Buffer pointers, descriptor pointers and both FSMs return to idle. A partial datagram is discarded. Reset takes priority over every other event.
- Match rule: is_udp=1 and udp_dst_port-PORT_BASE < NUM_PORTS, computed as unsigned 16-bit. Channel = udp_dst_port-PORT_BASE.
- Write FSM, states W_IDLE, W_ACCEPT, W_DISCARD.
  - W_IDLE, first payload byte arrives:
    - Match and descriptor FIFO not full: go to W_ACCEPT. Latch channel, src_ip, src_mac and udp_src_port. Write the byte at wr_tmp=wr_ptr and set len=1.
    - No match: go to W_DISCARD, no count.
    - Match but descriptor FIFO full: go to W_DISCARD and flag a drop.
  - W_ACCEPT:
    - Each byte is written at wr_tmp, then wr_tmp and len increment.
    - If a byte arrives while wr_tmp+1==rd_ptr (buffer full), go to W_DISCARD and flag a drop.
    - Beyond 1472 bytes: overflow, handled the same way as buffer full.
  - frame_done in W_ACCEPT:
    - frame_ok=1: commit. wr_ptr<=wr_tmp, push descriptor, pkt_cnt+1.
    - frame_ok=0: roll back. wr_tmp<=wr_ptr, drop_cnt+1.
  - frame_done in W_DISCARD: drop_cnt+1 if a drop was flagged; always roll back; go to W_IDLE.
  - frame_done in W_IDLE is a no-op. Zero-length datagrams are never forwarded or counted.
  - udp_payload_last carries no state effect; commit happens only at frame_done.
- Read FSM, states R_IDLE, R_LOAD, R_STREAM.
  - R_IDLE: descriptor FIFO not empty, go to R_LOAD.
  - R_LOAD, one cycle: pop descriptor, drive the descriptor outputs, issue the buffer read at rd_ptr.
  - R_STREAM:
    - out_valid=1 and out_data holds the byte at rd_ptr, via a registered read with prefetch.
    - On out_valid&out_ready: rd_ptr+1.
    - out_last=1 on byte number out_len.
    - Transfer of the last byte returns to R_IDLE.
  - Sustained throughput is 1 byte/cycle while out_ready=1.
  - Descriptor outputs are stable from R_LOAD until the last transfer.
- Latency: commit at cycle N gives out_valid at N+3 when the read side is idle.
- Handshake: out_data and out_last are held while out_valid&!out_ready.
- Simultaneous commit and read-pointer advance in the same cycle are both honoured.
- The free-space check uses rd_ptr registered at the start of that cycle.
- Pointers wrap modulo 2^BUF_AW.

Optional Feature:
- UDP_ROUTER_IP_FILTER_EN defined: the match rule additionally requires dst_ip==FPGA_IP or dst_ip==32'hFFFFFFFF. A mismatch is treated as no match (silent discard, no count).
- Undefined: dst_ip is ignored.

Test Plan:
- 10-byte datagram to port 5006 with frame_ok=1 and out_ready=1 -> out_chan=1, out_len=10, bytes in order, out_last on the 10th byte, pkt_cnt=1, out_valid 3 cycles after frame_done.
- Same datagram with frame_ok=0 -> no output, drop_cnt=1, buffer space fully restored; a following good datagram streams correctly.
- Datagram to port 5009 (NUM_PORTS=4) and datagram to port 5004 -> both silently discarded, both counters unchanged.
- BUF_AW=6 with out_ready=0: 40-byte datagram, then 40-byte datagram -> first commits, second is dropped (drop_cnt=1); after draining, a third 40-byte datagram is accepted.
- Eight 1-byte datagrams with out_ready=0 and DESC_AW=3 -> 7 or 8 committed per depth; the ninth is dropped. Random out_ready backpressure preserves every byte and out_last position.
- Assert rst_n=0 mid-datagram and mid-stream -> outputs 0 next cycle; after release, a fresh datagram passes intact. With UDP_ROUTER_IP_FILTER_EN, a datagram with dst_ip=192.168.1.7 is discarded.

Source files
------------

// File: rtl/udp_port_router_if.sv
// rtl/udp_port_router_if.sv - committed-datagram byte stream plus per-datagram descriptor
interface udp_port_router_if #(
  parameter int CHAN_W = 2
);
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic              out_last;
  logic [CHAN_W-1:0] out_chan;
  logic [10:0]       out_len;
  logic [31:0]       out_src_ip;
  logic [47:0]       out_src_mac;
  logic [15:0]       out_src_port;

  modport master (
    output out_valid, out_data, out_last, out_chan, out_len,
           out_src_ip, out_src_mac, out_src_port,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_last, out_chan, out_len,
           out_src_ip, out_src_mac, out_src_port,
    output out_ready
  );
endinterface

// File: rtl/udp_port_router.sv
// rtl/udp_port_router.sv - stages UDP payloads for NUM_PORTS listen ports, commits on good frames, streams out
// Optional dst_ip filter: define UDP_ROUTER_IP_FILTER_EN.
module udp_port_router #(
  parameter int          NUM_PORTS = 4,
  parameter logic [15:0] PORT_BASE = 16'd5005,
  parameter int          BUF_AW    = 11,
  parameter int          DESC_AW   = 3,
  parameter logic [31:0] FPGA_IP   = 32'hC0A80164
) (
  input  logic                clk50,
  input  logic                rst_n,
  input  logic                is_udp,
  input  logic [31:0]         dst_ip,
  input  logic [31:0]         src_ip,
  input  logic [47:0]         src_mac,
  input  logic [15:0]         udp_src_port,
  input  logic [15:0]         udp_dst_port,
  input  logic [7:0]          udp_payload,
  input  logic                udp_payload_valid,
  input  logic                udp_payload_last,
  input  logic                frame_done,
  input  logic                frame_ok,
  udp_port_router_if.master   o,
  output logic [15:0]         drop_cnt,
  output logic [15:0]         pkt_cnt
);
  localparam int          CW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int          DW      = 11 + CW + 32 + 48 + 16;
  localparam logic [10:0] MAX_LEN = 11'd1472;

  typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_DISCARD} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_STREAM} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [7:0]         buf_mem [2**BUF_AW];
  logic [DW-1:0]      desc_mem [2**DESC_AW];

  logic [BUF_AW-1:0]  wr_ptr_q, wr_ptr_d, wr_tmp_q, wr_tmp_d, rd_ptr_q, rd_ptr_d, rd_addr_d;
  logic [DESC_AW-1:0] dwr_q, dwr_d, drd_q, drd_d;
  logic [10:0]        len_q, len_d, rem_q, rem_d;
  logic               drop_flag_q, drop_flag_d;
  logic [CW-1:0]      chan_q, chan_d;
  logic [31:0]        sip_q, sip_d;
  logic [47:0]        smac_q, smac_d;
  logic [15:0]        sport_q, sport_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d, pkt_cnt_q, pkt_cnt_d;
  logic [DW-1:0]      desc_out_q, desc_out_d;
  logic [7:0]         rd_data_q;
  logic               mem_we, desc_push, desc_pop;
  logic [15:0]        port_off;
  logic               ip_ok, hit, buf_full, desc_full, desc_empty, xfer;
  logic               unused_in;

`ifdef UDP_ROUTER_IP_FILTER_EN
  assign ip_ok     = (dst_ip == FPGA_IP) || (dst_ip == 32'hFFFF_FFFF);
  assign unused_in = udp_payload_last;
`else
  assign ip_ok     = 1'b1;
  assign unused_in = ^{dst_ip, FPGA_IP, udp_payload_last};
`endif

  // Unsigned wrap makes ports below PORT_BASE land far above NUM_PORTS.
  assign port_off   = udp_dst_port - PORT_BASE;
  assign hit        = is_udp && ip_ok && (port_off < 16'(NUM_PORTS));
  assign buf_full   = (wr_tmp_q + 1'b1) == rd_ptr_q;
  assign desc_full  = (dwr_q + 1'b1) == drd_q;
  assign desc_empty = dwr_q == drd_q;
  assign xfer       = (r_state_q == R_STREAM) && o.out_ready;

  always_comb begin
    w_state_d   = w_state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_tmp_d    = wr_tmp_q;
    len_d       = len_q;
    drop_flag_d = drop_flag_q;
    chan_d      = chan_q;
    sip_d       = sip_q;
    smac_d      = smac_q;
    sport_d     = sport_q;
    drop_cnt_d  = drop_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    mem_we      = 1'b0;
    desc_push   = 1'b0;
    case (w_state_q)
      W_IDLE: if (udp_payload_valid) begin
        if (!hit) begin
          w_state_d   = W_DISCARD;
          drop_flag_d = 1'b0;
        end else if (desc_full || buf_full) begin
          w_state_d   = W_DISCARD;
          drop_flag_d = 1'b1;
        end else begin
          w_state_d = W_ACCEPT;
          chan_d    = port_off[CW-1:0];
          sip_d     = src_ip;
          smac_d    = src_mac;
          sport_d   = udp_src_port;
          mem_we    = 1'b1;
          wr_tmp_d  = wr_tmp_q + 1'b1;
          len_d     = 11'd1;
        end
      end
      W_ACCEPT: if (frame_done) begin
        w_state_d = W_IDLE;
        if (frame_ok) begin
          wr_ptr_d  = wr_tmp_q;
          desc_push = 1'b1;
          pkt_cnt_d = pkt_cnt_q + 16'd1;
        end else begin
          wr_tmp_d   = wr_ptr_q;
          drop_cnt_d = drop_cnt_q + 16'd1;
        end
      end else if (udp_payload_valid) begin
        if (buf_full || len_q == MAX_LEN) begin
          w_state_d   = W_DISCARD;
          drop_flag_d = 1'b1;
        end else begin
          mem_we   = 1'b1;
          wr_tmp_d = wr_tmp_q + 1'b1;
          len_d    = len_q + 11'd1;
        end
      end
      W_DISCARD: if (frame_done) begin
        if (drop_flag_q) drop_cnt_d = drop_cnt_q + 16'd1;
        wr_tmp_d    = wr_ptr_q;
        drop_flag_d = 1'b0;
        w_state_d   = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // The buffer is read every cycle so the next byte is already prefetched on each transfer.
  always_comb begin
    r_state_d  = r_state_q;
    rd_ptr_d   = rd_ptr_q;
    rd_addr_d  = rd_ptr_q;
    rem_d      = rem_q;
    desc_out_d = desc_out_q;
    desc_pop   = 1'b0;
    case (r_state_q)
      R_IDLE: if (!desc_empty) r_state_d = R_LOAD;
      R_LOAD: begin
        desc_pop   = 1'b1;
        desc_out_d = desc_mem[drd_q];
        rem_d      = desc_mem[drd_q][DW-1 -: 11];
        r_state_d  = R_STREAM;
      end
      R_STREAM: if (xfer) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        rd_addr_d = rd_ptr_q + 1'b1;
        rem_d     = rem_q - 11'd1;
        if (rem_q == 11'd1) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    dwr_d = desc_push ? dwr_q + 1'b1 : dwr_q;
    drd_d = desc_pop  ? drd_q + 1'b1 : drd_q;
  end

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      wr_ptr_q    <= '0;
      wr_tmp_q    <= '0;
      rd_ptr_q    <= '0;
      dwr_q       <= '0;
      drd_q       <= '0;
      len_q       <= '0;
      rem_q       <= '0;
      drop_flag_q <= 1'b0;
      chan_q      <= '0;
      sip_q       <= '0;
      smac_q      <= '0;
      sport_q     <= '0;
      drop_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      desc_out_q  <= '0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_tmp_q    <= wr_tmp_d;
      rd_ptr_q    <= rd_ptr_d;
      dwr_q       <= dwr_d;
      drd_q       <= drd_d;
      len_q       <= len_d;
      rem_q       <= rem_d;
      drop_flag_q <= drop_flag_d;
      chan_q      <= chan_d;
      sip_q       <= sip_d;
      smac_q      <= smac_d;
      sport_q     <= sport_d;
      drop_cnt_q  <= drop_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      desc_out_q  <= desc_out_d;
    end
  end

  always_ff @(posedge clk50) begin
    if (mem_we) buf_mem[wr_tmp_q] <= udp_payload;
    if (desc_push) desc_mem[dwr_q] <= {len_q, chan_q, sip_q, smac_q, sport_q};
    rd_data_q <= buf_mem[rd_addr_d];
  end

  assign o.out_valid = (r_state_q == R_STREAM);
  assign o.out_data  = (r_state_q == R_STREAM) ? rd_data_q : 8'd0;
  assign o.out_last  = (r_state_q == R_STREAM) && (rem_q == 11'd1);
  assign {o.out_len, o.out_chan, o.out_src_ip, o.out_src_mac, o.out_src_port} = desc_out_q;
  assign drop_cnt    = drop_cnt_q;
  assign pkt_cnt     = pkt_cnt_q;
endmodule
